meter_ctrl: RTL

METER_CTRL -- requirements
Module: meter_ctrl

---
 rtl/meter_pkg.sv | 46 ++++
 rtl/meter_blink.sv | 48 ++++
 rtl/meter_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/meter_pkg.sv
// +------------------------------------------------------------------+
// | meter_pkg : shared mode encoding, increments and preset values   |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
`default_nettype none

package meter_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE       = 2'd0,
    MODE_STEADY     = 2'd1,
    MODE_BLINK_SLOW = 2'd2,
    MODE_BLINK_FAST = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    BCD_IDLE = 2'd0,
    BCD_REQ  = 2'd1,
    BCD_DROP = 2'd2
  } bcd_state_t;

  localparam logic [15:0] c_inc_0    = 16'd50;
  localparam logic [15:0] c_inc_1    = 16'd150;
  localparam logic [15:0] c_inc_2    = 16'd200;
  localparam logic [15:0] c_inc_3    = 16'd500;
  localparam logic [15:0] c_preset_0 = 16'd10;
  localparam logic [15:0] c_preset_1 = 16'd205;

  function automatic logic [15:0] inc_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return c_inc_0;
      2'd1:    return c_inc_1;
      2'd2:    return c_inc_2;
      default: return c_inc_3;
    endcase
  endfunction

  function automatic mode_t mode_of(input logic [15:0] t, input logic [15:0] low);
    if (t == 16'd0)  return MODE_BLINK_SLOW;
    else if (t <= low) return MODE_BLINK_FAST;
    else             return MODE_STEADY;
  endfunction

endpackage

`default_nettype wire

// File: rtl/meter_blink.sv
// +------------------------------------------------------------------+
// | meter_blink : display blank generator driven by the 2 Hz strobe  |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

module meter_blink
  import meter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       tick_2hz,
  output logic       blank
);

  logic r_phase;
  logic r_blank;

  // Slow blink halves the strobe rate through r_phase; fast blink toggles on every strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
      r_blank <= 1'b0;
    end else begin
      case (mode_t'(mode))
        MODE_BLINK_FAST: begin
          if (tick_2hz) r_blank <= ~r_blank;
        end
        MODE_BLINK_SLOW: begin
          if (tick_2hz) begin
            r_phase <= ~r_phase;
            if (r_phase) r_blank <= ~r_blank;
          end
        end
        default: begin
          r_phase <= 1'b0;
          r_blank <= 1'b0;
        end
      endcase
    end
  end

  assign blank = r_blank;

endmodule

`default_nettype wire

// File: rtl/meter_ctrl.sv
// +------------------------------------------------------------------+
// | meter_ctrl : parking-meter time keeper with BCD handshake        |
// | Option     : METER_QUEUE_EN enables pending-flag add queue       |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
`default_nettype none

module meter_ctrl
  import meter_pkg::*;
#(
  parameter int MAX_TIME   = 9999,
  parameter int LOW_THRESH = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  add_req,
  input  logic [1:0]  preset_sw,
  input  logic        tick_1hz,
  input  logic        tick_2hz,
  output logic [15:0] times,
  output logic [1:0]  mode,
  output logic        blank,
  output logic        bcd_req,
  output logic [15:0] bcd_val,
  input  logic        bcd_ack
);

  localparam logic [15:0] c_max   = 16'(MAX_TIME);
  localparam logic [16:0] c_max17 = 17'(MAX_TIME);
  localparam logic [15:0] c_low   = 16'(LOW_THRESH);

  logic [1:0]  r_preset_d;
  logic [1:0]  w_rise;
  logic        w_preset;
  logic [3:0]  w_cand;
  logic        w_hit;
  logic [1:0]  w_idx;
  logic [16:0] w_sum;
  logic [15:0] w_t_add;
  logic [15:0] w_t_nxt;
  logic        w_load;
  logic [15:0] r_times;
  logic [15:0] r_times_d;
  logic        r_started;
  mode_t       r_mode;
  logic        w_chg;
  bcd_state_t  r_bcd;
  bcd_state_t  w_bcd_nxt;
  logic        r_dirty;
  logic        w_dirty_nxt;
  logic        w_snap;
  logic [15:0] r_bcd_val;

  assign w_rise   = preset_sw & ~r_preset_d;
  assign w_preset = |w_rise;

`ifdef METER_QUEUE_EN
  logic [3:0] r_pend;

  assign w_cand = r_pend | add_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_pend <= 4'd0;
    else if (w_preset) r_pend <= 4'd0;
    else               r_pend <= w_cand & ~(4'd1 << w_idx);
  end
`else
  assign w_cand = add_req;
`endif

  always_comb begin
    w_hit = 1'b0;
    w_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_hit = 1'b1;
        w_idx = 2'(i);
      end
    end
  end

  // Add or preset first, then the countdown acts on that result in the same cycle.
  always_comb begin
    w_sum  = {1'b0, r_times} + {1'b0, inc_of(w_idx)};
    w_load = 1'b1;
    if (w_rise[0])      w_t_add = c_preset_0;
    else if (w_rise[1]) w_t_add = c_preset_1;
    else if (w_hit)     w_t_add = (w_sum > c_max17) ? c_max : w_sum[15:0];
    else begin
      w_t_add = r_times;
      w_load  = 1'b0;
    end
    w_t_nxt = w_t_add;
    if (tick_1hz && (w_t_add != 16'd0)) begin
      if ((w_t_add > c_low) || w_t_add[0]) w_t_nxt = w_t_add - 16'd1;
      else                                 w_t_nxt = w_t_add - 16'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_times    <= 16'd0;
      r_times_d  <= 16'd0;
      r_preset_d <= 2'd0;
      r_started  <= 1'b0;
      r_mode     <= MODE_IDLE;
    end else begin
      r_times    <= w_t_nxt;
      r_times_d  <= r_times;
      r_preset_d <= preset_sw;
      r_started  <= r_started | w_load;
      r_mode     <= r_started ? mode_of(r_times, c_low) : MODE_IDLE;
    end
  end

  assign w_chg = (r_times != r_times_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd     <= BCD_IDLE;
      r_dirty   <= 1'b0;
      r_bcd_val <= 16'd0;
    end else begin
      r_bcd   <= w_bcd_nxt;
      r_dirty <= w_dirty_nxt;
      if (w_snap) r_bcd_val <= r_times;
    end
  end

  // Changes seen while a request is open are remembered and re-sent after the drop cycle.
  always_comb begin
    w_bcd_nxt   = r_bcd;
    w_dirty_nxt = r_dirty;
    w_snap      = 1'b0;
    case (r_bcd)
      BCD_IDLE: begin
        if (w_chg) begin
          w_bcd_nxt = BCD_REQ;
          w_snap    = 1'b1;
        end
      end
      BCD_REQ: begin
        w_dirty_nxt = r_dirty | w_chg;
        if (bcd_ack) w_bcd_nxt = BCD_DROP;
      end
      BCD_DROP: begin
        if (r_dirty || w_chg) begin
          w_bcd_nxt   = BCD_REQ;
          w_snap      = 1'b1;
          w_dirty_nxt = 1'b0;
        end else begin
          w_bcd_nxt = BCD_IDLE;
        end
      end
      default: begin
        w_bcd_nxt   = BCD_IDLE;
        w_dirty_nxt = 1'b0;
      end
    endcase
  end

  meter_blink u_blink (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (r_mode),
    .tick_2hz (tick_2hz),
    .blank    (blank)
  );

  assign times   = r_times;
  assign mode    = r_mode;
  assign bcd_req = (r_bcd == BCD_REQ);
  assign bcd_val = r_bcd_val;

endmodule

`default_nettype wire
